// File: rtl/game_sequencer.sv
// Frogger game controller: sequences idle/play/death/level-up/game-over phases,
// owns level and lives, and paces the car movement strobe by level.
module game_sequencer #(
   parameter int START_LIVES  = 3,
   parameter int MAX_LEVEL    = 99,
   parameter int BASE_PERIOD  = 30,
   parameter int MIN_PERIOD   = 4,
   parameter int DEATH_FRAMES = 60,
   parameter int WIN_FRAMES   = 60
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Start,
   input  logic       i_Frame_Tick,
   input  logic       i_Frog_Hit,
   input  logic       i_Frog_Home,
   output logic [2:0] o_State,
   output logic [6:0] o_Level,
   output logic [1:0] o_Lives,
   output logic       o_Move_En,
   output logic       o_Car_Step,
   output logic       o_Frog_Reset,
   output logic       o_Flash
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_PLAY      = 3'd1;
   localparam logic [2:0] S_DYING     = 3'd2;
   localparam logic [2:0] S_LEVEL_UP  = 3'd3;
   localparam logic [2:0] S_GAME_OVER = 3'd4;

   localparam logic [6:0] LEVEL_ONE  = 7'd1;
   localparam logic [6:0] LEVEL_MAX  = 7'(MAX_LEVEL);
   localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
   localparam logic [6:0] DEATH_LAST = 7'(DEATH_FRAMES - 1);
   localparam logic [6:0] WIN_LAST   = 7'(WIN_FRAMES - 1);
   localparam logic [5:0] BASE_P     = 6'(BASE_PERIOD);
   localparam logic [5:0] MIN_P      = 6'(MIN_PERIOD);
   // Highest level whose unclamped period is still >= MIN_PERIOD.
   localparam logic [6:0] FAST_LEVEL = 7'((BASE_PERIOD - MIN_PERIOD) / 2 + 1);

   logic [2:0] state_q,      state_d;
   logic [6:0] level_q,      level_d;
   logic [1:0] lives_q,      lives_d;
   logic [6:0] timer_q,      timer_d;
   logic [5:0] step_cnt_q,   step_cnt_d;
   logic       start_q;
   logic       car_step_q,   car_step_d;
   logic       frog_reset_q, frog_reset_d;
   logic       flash_q,      flash_d;
   logic       move_en_q,    move_en_d;

   logic       start_edge_s;
   logic       entering_s;
   logic       play_entry_s;
   logic       phase_timed_s;
   logic [5:0] period_s;
   logic [5:0] period_last_s;

   assign start_edge_s  = i_Start & ~start_q;
   assign entering_s    = (state_d != state_q);
   assign play_entry_s  = entering_s & (state_d == S_PLAY);
   assign phase_timed_s = (state_q == S_DYING) | (state_q == S_LEVEL_UP);

   // Car step period from the current level; the clamp is decided on the level
   // so the 6-bit subtraction only runs where its true result is 1..63.
   always_comb begin
      if (level_q > FAST_LEVEL) begin
         period_s = MIN_P;
      end else begin
         period_s = BASE_P - {level_q[4:0], 1'b0} + 6'd2;
      end
      period_last_s = period_s - 6'd1;
   end

   // Phase sequencing together with the level and lives bookkeeping.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      lives_d = lives_q;
      case (state_q)
         S_IDLE: begin
            if (start_edge_s) begin
               state_d = S_PLAY;
               level_d = LEVEL_ONE;
               lives_d = LIVES_INIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PLAY: begin
            if (i_Frog_Hit) begin
               state_d = S_DYING;
               lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            end else if (i_Frog_Home) begin
               state_d = S_LEVEL_UP;
               level_d = (level_q >= LEVEL_MAX) ? LEVEL_MAX : level_q + 7'd1;
            end else begin
               state_d = S_PLAY;
            end
         end
         S_DYING: begin
            if (i_Frame_Tick && (timer_q == DEATH_LAST)) begin
               state_d = (lives_q == 2'd0) ? S_GAME_OVER : S_PLAY;
            end else begin
               state_d = S_DYING;
            end
         end
         S_LEVEL_UP: begin
            if (i_Frame_Tick && (timer_q == WIN_LAST)) begin
               state_d = S_PLAY;
            end else begin
               state_d = S_LEVEL_UP;
            end
         end
         S_GAME_OVER: begin
            if (start_edge_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_GAME_OVER;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Phase timer, car step counter and the registered output strobes.
   always_comb begin
      if (entering_s) begin
         timer_d = 7'd0;
      end else if (phase_timed_s && i_Frame_Tick) begin
         timer_d = timer_q + 7'd1;
      end else begin
         timer_d = timer_q;
      end

      // >= so a count left beyond a shortened period fires instead of wrapping.
      car_step_d = (state_q == S_PLAY) & i_Frame_Tick & (step_cnt_q >= period_last_s);

      if (play_entry_s) begin
         step_cnt_d = 6'd0;
      end else if ((state_q == S_PLAY) && i_Frame_Tick) begin
         step_cnt_d = car_step_d ? 6'd0 : step_cnt_q + 6'd1;
      end else begin
         step_cnt_d = step_cnt_q;
      end

      frog_reset_d = play_entry_s;
      move_en_d    = (state_d == S_PLAY);
      flash_d      = (state_d == S_DYING) & timer_d[3];
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state_q      <= S_IDLE;
         level_q      <= LEVEL_ONE;
         lives_q      <= LIVES_INIT;
         timer_q      <= 7'd0;
         step_cnt_q   <= 6'd0;
         start_q      <= 1'b0;
         car_step_q   <= 1'b0;
         frog_reset_q <= 1'b0;
         flash_q      <= 1'b0;
         move_en_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         level_q      <= level_d;
         lives_q      <= lives_d;
         timer_q      <= timer_d;
         step_cnt_q   <= step_cnt_d;
         start_q      <= i_Start;
         car_step_q   <= car_step_d;
         frog_reset_q <= frog_reset_d;
         flash_q      <= flash_d;
         move_en_q    <= move_en_d;
      end
   end

   assign o_State      = state_q;
   assign o_Level      = level_q;
   assign o_Lives      = lives_q;
   assign o_Move_En    = move_en_q;
   assign o_Car_Step   = car_step_q;
   assign o_Frog_Reset = frog_reset_q;
   assign o_Flash      = flash_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a phase-level reference model predicts every
// cycle's outputs into a queue; a monitor pops and compares after each clock edge.
module tb_game_sequencer;

   localparam int START_LIVES  = 3;
   localparam int MAX_LEVEL    = 99;
   localparam int BASE_PERIOD  = 30;
   localparam int MIN_PERIOD   = 4;
   localparam int DEATH_FRAMES = 60;
   localparam int WIN_FRAMES   = 60;

   localparam int P_IDLE = 0, P_PLAY = 1, P_DYING = 2, P_LVL = 3, P_OVER = 4;

   logic       clk   = 1'b0;
   logic       rst_l = 1'b0;
   logic       start = 1'b0;
   logic       tick  = 1'b0;
   logic       hit   = 1'b0;
   logic       home  = 1'b0;
   logic [2:0] o_state;
   logic [6:0] o_level;
   logic [1:0] o_lives;
   logic       o_move, o_step, o_freset, o_flash;

   always #5 clk = ~clk;

   game_sequencer #(
      .START_LIVES(START_LIVES), .MAX_LEVEL(MAX_LEVEL), .BASE_PERIOD(BASE_PERIOD),
      .MIN_PERIOD(MIN_PERIOD), .DEATH_FRAMES(DEATH_FRAMES), .WIN_FRAMES(WIN_FRAMES)
   ) dut (
      .i_Clk(clk), .i_Rst_L(rst_l), .i_Start(start), .i_Frame_Tick(tick),
      .i_Frog_Hit(hit), .i_Frog_Home(home),
      .o_State(o_state), .o_Level(o_level), .o_Lives(o_lives), .o_Move_En(o_move),
      .o_Car_Step(o_step), .o_Frog_Reset(o_freset), .o_Flash(o_flash)
   );

   typedef struct {
      logic [2:0] st;
      logic [6:0] lv;
      logic [1:0] li;
      logic       mv, cs, fr, fl;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model state: game phase, counters as plain integers.
   int m_phase = P_IDLE, m_level = 1, m_lives = START_LIVES;
   int m_timer = 0, m_ticks = 0;
   bit m_startq = 1'b0;

   function automatic int car_period(int lvl);
      int p;
      p = BASE_PERIOD - 2 * (lvl - 1);
      return (p < MIN_PERIOD) ? MIN_PERIOD : p;
   endfunction

   task automatic model(input bit r, s, t, h, m, output exp_t e);
      int prev;
      bit st_edge;
      e.cs = 1'b0;
      if (!r) begin
         m_phase = P_IDLE; m_level = 1; m_lives = START_LIVES;
         m_timer = 0; m_ticks = 0; m_startq = 1'b0;
         prev = P_IDLE;
      end else begin
         st_edge  = s && !m_startq;
         m_startq = s;
         prev     = m_phase;
         case (prev)
            P_IDLE: if (st_edge) begin m_phase = P_PLAY; m_level = 1; m_lives = START_LIVES; end
            P_PLAY: begin
               if (t) begin
                  m_ticks++;
                  if (m_ticks >= car_period(m_level)) begin e.cs = 1'b1; m_ticks = 0; end
               end
               if (h) begin m_phase = P_DYING; if (m_lives > 0) m_lives--; end
               else if (m) begin m_phase = P_LVL; if (m_level < MAX_LEVEL) m_level++; end
            end
            P_DYING: if (t) begin
               if (m_timer == DEATH_FRAMES - 1) m_phase = (m_lives == 0) ? P_OVER : P_PLAY;
               else m_timer++;
            end
            P_LVL: if (t) begin
               if (m_timer == WIN_FRAMES - 1) m_phase = P_PLAY;
               else m_timer++;
            end
            default: if (st_edge) m_phase = P_IDLE;
         endcase
         if (m_phase != prev) begin
            m_timer = 0;
            if (m_phase == P_PLAY) m_ticks = 0;
         end
      end
      e.st = 3'(m_phase);
      e.lv = 7'(m_level);
      e.li = 2'(m_lives);
      e.mv = (m_phase == P_PLAY);
      e.fr = r && (m_phase == P_PLAY) && (prev != P_PLAY);
      e.fl = (m_phase == P_DYING) && (((m_timer / 8) % 2) == 1);
   endtask

   task automatic cyc(input bit r, s, t, h, m, input string tag);
      exp_t e;
      @(negedge clk);
      rst_l = r; start = s; tick = t; hit = h; home = m;
      model(r, s, t, h, m, e);
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   function automatic bit nz(int noise, int which);
      if (which == 0) return ((noise & 1) != 0) && ($urandom_range(1, 0) == 1);
      return ((noise & 2) != 0) && ($urandom_range(3, 0) == 0);
   endfunction

   // n frame ticks, each preceded by 0..maxgap idle cycles; noise bit0 toggles start,
   // bit1 sprinkles hit/home (only meaningful outside PLAY).
   task automatic ticks(int n, int maxgap, int noise, string tag);
      for (int i = 0; i < n; i++) begin
         int g;
         g = $urandom_range(maxgap, 0);
         for (int k = 0; k < g; k++) cyc(1'b1, nz(noise, 0), 1'b0, nz(noise, 1), nz(noise, 1), tag);
         cyc(1'b1, nz(noise, 0), 1'b1, nz(noise, 1), nz(noise, 1), tag);
      end
   endtask

   task automatic idle(int n, bit s, string tag);
      for (int i = 0; i < n; i++) cyc(1'b1, s, 1'b0, 1'b0, 1'b0, tag);
   endtask

   // Monitor: one expected vector per clock edge, sampled 1 time unit after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({o_state, o_level, o_lives, o_move, o_step, o_freset, o_flash} !==
                {e.st, e.lv, e.li, e.mv, e.cs, e.fr, e.fl}) begin
               n_bad++;
               $display("FAIL %s vec %0d: got st=%0d lv=%0d li=%0d mv=%0b cs=%0b fr=%0b fl=%0b, want st=%0d lv=%0d li=%0d mv=%0b cs=%0b fr=%0b fl=%0b",
                        e.tag, n_vec, o_state, o_level, o_lives, o_move, o_step, o_freset, o_flash,
                        e.st, e.lv, e.li, e.mv, e.cs, e.fr, e.fl);
            end
         end
      end
   end

   initial begin
      bit s_cur;
      // Reset with start held, release the button, then a real press.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "reset");
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "reset");
      idle(4, 1'b0, "idle_wait");
      idle(3, 1'b1, "start_play");
      idle(2, 1'b0, "start_release");

      ticks(60, 2, 1, "play_lvl1");
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "hit_l3");
      ticks(DEATH_FRAMES, 1, 3, "dying");

      for (int i = 0; i < 19; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "home");
         ticks(WIN_FRAMES, 0, 3, "level_up");
      end
      ticks(24, 1, 1, "play_lvl20");

      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "hit_and_home");
      ticks(DEATH_FRAMES, 0, 3, "dying2");

      for (int i = 0; i < 79; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "home_climb");
         ticks(WIN_FRAMES, 0, 2, "level_up_climb");
      end
      ticks(8, 0, 0, "play_lvl99");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "home_at_max");
      ticks(25, 0, 3, "level_up_max");
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "reset_mid_levelup");
      idle(3, 1'b0, "post_reset");

      idle(2, 1'b1, "restart");
      idle(1, 1'b0, "restart_release");
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "home_l2");
      ticks(WIN_FRAMES, 0, 0, "level_up_l2");
      for (int i = 0; i < 3; i++) begin
         ticks(5, 1, 0, "play_before_hit");
         cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "hit_series");
         ticks(DEATH_FRAMES, 0, 3, "dying_series");
      end
      idle(4, 1'b0, "game_over_hold");
      idle(2, 1'b1, "go_to_idle");
      idle(2, 1'b0, "idle_after_go");
      idle(2, 1'b1, "second_start");
      idle(1, 1'b0, "second_release");

      // Random soak against the model.
      s_cur = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(7, 0) == 0) s_cur = ~s_cur;
         cyc($urandom_range(599, 0) != 0, s_cur, $urandom_range(2, 0) == 0,
             $urandom_range(59, 0) == 0, $urandom_range(39, 0) == 0, "soak");
      end

      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
         n_bad += exp_q.size();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
